uart_sys_ctrl: RTL and testbench
================================

Name: uart_sys_ctrl

Overview:
Single-clock command controller between the UART receive and transmit datapaths and a register file. It parses byte frames delivered by the UART receiver, issues register-file write and read strobes, and returns read data through the UART transmitter using its valid/busy handshake. It is the sequencer for the UART link inside the system top level.

Parameters:
DATA_WIDTH, 8, byte width on UART and register-file data buses
ADDR_WIDTH, 4, register-file address width; taken from the low bits of the address byte
RD_TIMEOUT, 16, cycles to wait for RF_RD_DATA_VLD before returning the error byte
ERR_BYTE, 8'hEE, byte transmitted on read timeout

Ports:
CLK  in  1  system clock; all logic rising-edge
RST  in  1  synchronous, active-low reset
RX_P_DATA  in  DATA_WIDTH  byte from UART receiver
RX_D_VLD  in  1  one-cycle pulse: RX_P_DATA valid
TX_BUSY  in  1  UART transmitter busy, already synchronised to CLK
TX_P_DATA  out  DATA_WIDTH  byte to UART transmitter
TX_D_VLD  out  1  one-cycle request pulse to the transmitter
RF_ADDR  out  ADDR_WIDTH  register-file address
RF_WR_DATA  out  DATA_WIDTH  register-file write data
RF_WR_EN  out  1  one-cycle write strobe
RF_RD_EN  out  1  one-cycle read strobe
RF_RD_DATA  in  DATA_WIDTH  register-file read data
RF_RD_DATA_VLD  in  1  read data valid pulse
CMD_ERR  out  1  sticky flag: unknown opcode received or RX byte dropped; cleared only by reset

Behaviour:
- Reset (RST=0 at a CLK edge): state=IDLE; TX_P_DATA=0, TX_D_VLD=0, RF_ADDR=0, RF_WR_DATA=0, RF_WR_EN=0, RF_RD_EN=0, CMD_ERR=0; timeout counter=0. Reset asserted mid-frame aborts the frame with no strobe issued.
- All outputs are registered.
- Opcodes: 8'hAA write frame = AA, ADDR, DATA. 8'hBB read frame = BB, ADDR. Any other first byte is discarded and sets CMD_ERR.
- States:
  - IDLE: on RX_D_VLD, AA -> WR_ADDR; BB -> RD_ADDR; other -> IDLE and set CMD_ERR.
  - WR_ADDR: on RX_D_VLD, latch RF_ADDR = byte[ADDR_WIDTH-1:0] (upper bits ignored) -> WR_DATA.
  - WR_DATA: on RX_D_VLD, latch RF_WR_DATA and pulse RF_WR_EN next cycle for exactly 1 cycle -> IDLE. Write latency is 1 cycle after the data byte's RX_D_VLD.
  - RD_ADDR: on RX_D_VLD, latch RF_ADDR, pulse RF_RD_EN for 1 cycle, clear the counter -> RD_WAIT.
  - RD_WAIT: on RF_RD_DATA_VLD, latch TX_P_DATA = RF_RD_DATA -> TX_SEND. Otherwise the counter increments; when the counter reaches RD_TIMEOUT-1 without valid, TX_P_DATA = ERR_BYTE -> TX_SEND. If valid and timeout coincide, data wins.
  - TX_SEND: when TX_BUSY=0, pulse TX_D_VLD for 1 cycle -> TX_WAIT. While TX_BUSY=1, hold and do not pulse.
  - TX_WAIT: wait for TX_BUSY=1 -> IDLE. TX_P_DATA holds its value until the next load.
- RX_D_VLD in RD_WAIT, TX_SEND or TX_WAIT: byte dropped, CMD_ERR set, state unaffected.
- RF_RD_DATA_VLD outside RD_WAIT is ignored.
- RF_WR_EN and RF_RD_EN are never high in the same cycle.
- At most one TX_D_VLD pulse is issued per read frame.
- No inter-byte timeout: a partial frame waits indefinitely.

Decomposition:
- Shared package uart_sys_pkg holds:
  - state enum: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND, TX_WAIT
  - opcode constants: OP_WR = 8'hAA, OP_RD = 8'hBB
  - default ERR_BYTE
- The read-timeout counter is simple enough to stay inline.
- No sub-module. A single FSM with registered outputs is natural.

Test Plan:
1. Write: bytes AA, 03, 5C with RX_D_VLD pulses -> exactly one RF_WR_EN cycle with RF_ADDR=3 and RF_WR_DATA=5C, 1 cycle after the third pulse; no TX_D_VLD.
2. Read: bytes BB, 07; model returns 3A two cycles after RF_RD_EN with TX_BUSY=0 -> TX_D_VLD single pulse with TX_P_DATA=3A; state returns to IDLE after TX_BUSY rises.
3. Read timeout: bytes BB, 02, RF_RD_DATA_VLD never asserted, RD_TIMEOUT=16 -> TX_P_DATA=EE and TX_D_VLD pulses 16 cycles after RF_RD_EN.
4. Busy hold: read completes while TX_BUSY=1 for 20 cycles -> TX_D_VLD stays 0 until the first cycle TX_BUSY=0, then pulses once.
5. Errors: byte 11 in IDLE -> CMD_ERR=1 and no strobes; byte received during RD_WAIT -> dropped and the read still completes. CMD_ERR remains 1 until RST=0.
6. Reset mid-frame: AA, 04, then RST=0 for 1 cycle, then 5C -> no RF_WR_EN; all outputs 0; the next frame AA, 01, 22 writes address 1.

Source files
------------

// File: rtl/uart_sys_pkg.sv
// Shared definitions for the UART system command controller.
//   state_e      : controller FSM states
//   OP_WR, OP_RD : frame opcodes (first byte of a frame)
//   ERR_BYTE_DEF : default byte returned when a register read times out
package uart_sys_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5,
    TX_WAIT = 3'd6
  } state_e;

  localparam logic [7:0] OP_WR        = 8'hAA;
  localparam logic [7:0] OP_RD        = 8'hBB;
  localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;

endpackage

// File: rtl/uart_sys_ctrl.sv
// UART link sequencer: parses write (AA, ADDR, DATA) and read (BB, ADDR)
// frames from the UART receiver, strobes the register file, and returns
// read data (or an error byte on timeout) through the UART transmitter.
// Ports:
//   CLK, RST        : clock, synchronous active-low reset
//   RX_P_DATA/VLD   : received byte and its one-cycle valid pulse
//   TX_BUSY         : transmitter busy (already in CLK domain)
//   TX_P_DATA/D_VLD : byte to transmit and one-cycle request pulse
//   RF_ADDR, RF_WR_DATA, RF_WR_EN, RF_RD_EN : register-file request side
//   RF_RD_DATA, RF_RD_DATA_VLD              : register-file read response
//   CMD_ERR         : sticky error flag, cleared only by reset
// All outputs are registered.
module uart_sys_ctrl
  import uart_sys_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    RD_TIMEOUT = 16,
  parameter logic [DATA_WIDTH-1:0] ERR_BYTE   = DATA_WIDTH'(ERR_BYTE_DEF)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  TX_BUSY,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic [ADDR_WIDTH-1:0] RF_ADDR,
  output logic [DATA_WIDTH-1:0] RF_WR_DATA,
  output logic                  RF_WR_EN,
  output logic                  RF_RD_EN,
  input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
  input  logic                  RF_RD_DATA_VLD,
  output logic                  CMD_ERR
);

  localparam int CNT_W = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
  // The counter is 0 in the cycle the read strobe is out. Deciding the
  // timeout when it holds RD_TIMEOUT-2 (about to reach RD_TIMEOUT-1) puts
  // the error byte's TX_D_VLD exactly RD_TIMEOUT cycles after RF_RD_EN.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(RD_TIMEOUT - 2);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_vld_q, tx_vld_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    wr_en_q, wr_en_d;
  logic                    rd_en_q, rd_en_d;
  logic                    cmd_err_q, cmd_err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = 1'b0;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    cmd_err_d = cmd_err_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == DATA_WIDTH'(OP_WR))      state_d = WR_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(OP_RD)) state_d = RD_ADDR;
          else                                      cmd_err_d = 1'b1;
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_d = 1'b1;
          cnt_d   = '0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // Read data takes priority over a coincident timeout.
        if (RF_RD_DATA_VLD) begin
          tx_data_d = RF_RD_DATA;
          state_d   = TX_SEND;
        end else if (cnt_q == TMO_LAST) begin
          tx_data_d = ERR_BYTE;
          state_d   = TX_SEND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TX_SEND: begin
        if (!TX_BUSY) begin
          tx_vld_d = 1'b1;
          state_d  = TX_WAIT;
        end
      end
      TX_WAIT: begin
        // Hold off new frames until the transmitter acknowledges by going busy.
        if (TX_BUSY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A byte arriving while a read is in flight cannot be parsed: drop it.
    if (RX_D_VLD && (state_q == RD_WAIT || state_q == TX_SEND ||
                     state_q == TX_WAIT)) begin
      cmd_err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      cmd_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      cmd_err_q <= cmd_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign TX_P_DATA  = tx_data_q;
  assign TX_D_VLD   = tx_vld_q;
  assign RF_ADDR    = addr_q;
  assign RF_WR_DATA = wr_data_q;
  assign RF_WR_EN   = wr_en_q;
  assign RF_RD_EN   = rd_en_q;
  assign CMD_ERR    = cmd_err_q;

endmodule

// File: tb/tb_uart_sys_ctrl.sv
// Self-checking bench for uart_sys_ctrl: table of write/read frames plus
// hand-written error, sticky-flag and mid-frame reset sequences. A negedge
// monitor pops expected strobe/transmit events from a scoreboard queue.
module tb_uart_sys_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_vld;
  logic [3:0] rf_addr;
  logic [7:0] rf_wr_data;
  logic       rf_wr_en;
  logic       rf_rd_en;
  logic [7:0] rf_rd_data;
  logic       rf_rd_vld;
  logic       cmd_err;

  uart_sys_ctrl dut (
    .CLK(clk), .RST(rst_n),
    .RX_P_DATA(rx_data), .RX_D_VLD(rx_vld), .TX_BUSY(tx_busy),
    .TX_P_DATA(tx_data), .TX_D_VLD(tx_vld),
    .RF_ADDR(rf_addr), .RF_WR_DATA(rf_wr_data),
    .RF_WR_EN(rf_wr_en), .RF_RD_EN(rf_rd_en),
    .RF_RD_DATA(rf_rd_data), .RF_RD_DATA_VLD(rf_rd_vld),
    .CMD_ERR(cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // kind: 0 = register write, 1 = register read strobe, 2 = transmit
  typedef struct {
    int         kind;
    logic [3:0] addr;
    logic [7:0] data;
  } ev_t;
  ev_t exp_q[$];

  typedef struct {
    bit         wr;
    logic [7:0] ab;    // address byte as sent
    logic [7:0] db;    // write data, or value returned by the register file
    int         d;     // read response delay in cycles after RF_RD_EN (-1 never)
    int         busy;  // cycles TX_BUSY is held high from RF_RD_EN
    logic [3:0] ea;    // expected RF_ADDR
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input int kind, input logic [3:0] a, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_event: got kind %0d addr %0h data %0h expected none at %0t",
               kind, a, d, $time);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", kind, e.kind);
      if (kind != 2) chk("ev_addr", a, e.addr);
      if (kind != 1) chk("ev_data", d, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rf_wr_en && rf_rd_en) chk("wr_rd_exclusive", 1, 0);
      if (rf_wr_en) sb_pop(0, rf_addr, rf_wr_data);
      if (rf_rd_en) sb_pop(1, rf_addr, 8'h00);
      if (tx_vld)   sb_pop(2, 4'h0, tx_data);
    end
  end

  // Returns one cycle after the byte's RX_D_VLD edge (#1 past it).
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_vld  = 1'b1;
    @(posedge clk); #1;
    rx_vld  = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] ab, input logic [7:0] db, input logic [3:0] ea);
    exp_q.push_back('{kind: 0, addr: ea, data: db});
    send_byte(8'hAA);
    send_byte(ab);
    send_byte(db);
    @(negedge clk);
    chk("wr_latency", rf_wr_en, 1);
    @(negedge clk);
    chk("wr_single", rf_wr_en, 0);
  endtask

  task automatic do_read(input logic [7:0] ab, input logic [7:0] val, input int d,
                         input int busy, input logic [3:0] ea, input bit inject);
    logic [7:0] exp_d;
    int         base, exp_lat, n;
    // Data accepted when it arrives in wait cycles 0..14; otherwise timeout.
    if (d >= 0 && d <= 14) begin
      exp_d = val;
      base  = d + 2;
    end else begin
      exp_d = 8'hEE;
      base  = 16;
    end
    exp_lat = (busy + 1 > base) ? busy + 1 : base;
    exp_q.push_back('{kind: 1, addr: ea, data: 8'h00});
    exp_q.push_back('{kind: 2, addr: 4'h0, data: exp_d});
    tx_busy = (busy > 0);
    send_byte(8'hBB);
    send_byte(ab);
    n = -1;
    for (int k = 0; k < 60; k++) begin
      rf_rd_vld  = (k == d);
      rf_rd_data = val;
      tx_busy    = (k < busy);
      rx_vld     = inject && (k == 1);
      rx_data    = 8'h77;
      @(negedge clk);
      if (tx_vld) begin
        n = k;
        break;
      end
      @(posedge clk); #1;
    end
    chk("tx_latency", n, exp_lat);
    @(posedge clk); #1;
    rf_rd_vld = 1'b0;
    rx_vld    = 1'b0;
    tx_busy   = 1'b1;
    @(negedge clk);
    chk("tx_single", tx_vld, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    tx_busy = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{wr: 1, ab: 8'h03, db: 8'h5C, d: 0,  busy: 0,  ea: 4'h3};
    vecs[1] = '{wr: 1, ab: 8'hF3, db: 8'hA5, d: 0,  busy: 0,  ea: 4'h3};
    vecs[2] = '{wr: 1, ab: 8'h0F, db: 8'hFF, d: 0,  busy: 0,  ea: 4'hF};
    vecs[3] = '{wr: 0, ab: 8'h07, db: 8'h3A, d: 2,  busy: 0,  ea: 4'h7};
    vecs[4] = '{wr: 0, ab: 8'h02, db: 8'h11, d: -1, busy: 0,  ea: 4'h2};
    vecs[5] = '{wr: 0, ab: 8'h1A, db: 8'h5B, d: 14, busy: 0,  ea: 4'hA};
    vecs[6] = '{wr: 0, ab: 8'h04, db: 8'h66, d: 15, busy: 0,  ea: 4'h4};
    vecs[7] = '{wr: 0, ab: 8'h09, db: 8'hC3, d: 0,  busy: 0,  ea: 4'h9};
    vecs[8] = '{wr: 0, ab: 8'h06, db: 8'h81, d: 2,  busy: 20, ea: 4'h6};

    rst_n = 1'b0; rx_data = 8'h00; rx_vld = 1'b0; tx_busy = 1'b0;
    rf_rd_data = 8'h00; rf_rd_vld = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {tx_data, tx_vld, rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, cmd_err}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr) do_write(vecs[i].ab, vecs[i].db, vecs[i].ea);
      else do_read(vecs[i].ab, vecs[i].db, vecs[i].d, vecs[i].busy, vecs[i].ea, 1'b0);
    end
    chk("no_err_after_table", cmd_err, 0);

    // Unknown opcode in IDLE: flag only, no strobes.
    send_byte(8'h11);
    @(negedge clk);
    chk("bad_opcode_err", cmd_err, 1);
    // Byte during RD_WAIT is dropped; the read still completes.
    do_read(8'h05, 8'h4D, 3, 0, 4'h5, 1'b1);
    do_write(8'h08, 8'h9E, 4'h8);
    chk("err_sticky", cmd_err, 1);

    // Reset mid-frame aborts the write and clears everything.
    send_byte(8'hAA);
    send_byte(8'h04);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midframe_reset_outputs",
        {tx_data, tx_vld, rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, cmd_err}, 0);
    send_byte(8'h5C);
    @(negedge clk);
    chk("stray_byte_err", cmd_err, 1);
    do_write(8'h01, 8'h22, 4'h1);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
